// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   RV32I decode pipeline stage with a single-entry output register and a
//   valid/ready handshake on both sides. Register file reads happen in the
//   same cycle the instruction is presented. Operands are taken from the
//   writeback port when it targets the same source register, so a value
//   being written this cycle is not missed.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_in_valid / o_in_ready       upstream (fetch) handshake
//   i_in_instr, i_in_pc           instruction word and its PC
//   o_rf_read_address1/2          register file read indices (rs1/rs2)
//   i_rf_read_data1/2             register file read data (combinational)
//   i_wb_address/data/enable      writeback port, used for operand bypass
//   i_flush                       discard held and incoming instruction
//   o_out_valid / i_out_ready     downstream handshake
//   o_out_*                       registered decoded fields
// ---------------------------------------------------------------------------
module decode_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_instr,
  input  logic [31:0] i_in_pc,
  output logic [4:0]  o_rf_read_address1,
  output logic [4:0]  o_rf_read_address2,
  input  logic [31:0] i_rf_read_data1,
  input  logic [31:0] i_rf_read_data2,
  input  logic [4:0]  i_wb_address,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_enable,
  input  logic        i_flush,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_pc,
  output logic [31:0] o_out_rs1_value,
  output logic [31:0] o_out_rs2_value,
  output logic [31:0] o_out_imm,
  output logic [4:0]  o_out_rd,
  output logic [6:0]  o_out_opcode,
  output logic [2:0]  o_out_funct3,
  output logic [6:0]  o_out_funct7,
  output logic        o_out_illegal
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stateT;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;

  stateT       r_state;
  stateT       w_nextState;
  logic        w_accept;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm;
  logic        w_illegal;
  logic [31:0] w_rs1Value;
  logic [31:0] w_rs2Value;

  // Source indices go straight to the register file regardless of valid,
  // so the read data is ready by the time the instruction is accepted.
  assign w_opcode           = i_in_instr[6:0];
  assign w_rs1              = i_in_instr[19:15];
  assign w_rs2              = i_in_instr[24:20];
  assign o_rf_read_address1 = w_rs1;
  assign o_rf_read_address2 = w_rs2;

  assign o_out_valid = (r_state == FULL);
  assign o_in_ready  = !o_out_valid || i_out_ready;
  // A handshake during flush still completes upstream, but the word is dropped.
  assign w_accept    = i_in_valid && o_in_ready && !i_flush;

  // Operand selection: x0 always reads zero, and a writeback to x0 must
  // never be forwarded; otherwise a same-cycle write wins over the stale
  // register file value.
  function automatic logic [31:0] selectOperand(input logic [4:0]  index,
                                                input logic [31:0] rfData,
                                                input logic        wbEnable,
                                                input logic [4:0]  wbAddress,
                                                input logic [31:0] wbData);
    if (index == 5'd0)
      return 32'd0;
    else if (wbEnable && (wbAddress == index))
      return wbData;
    else
      return rfData;
  endfunction

  assign w_rs1Value = selectOperand(w_rs1, i_rf_read_data1, i_wb_enable, i_wb_address, i_wb_data);
  assign w_rs2Value = selectOperand(w_rs2, i_rf_read_data2, i_wb_enable, i_wb_address, i_wb_data);

  // Immediate reconstruction per instruction format. Anything that carries
  // no immediate (R-type, fence) or is not recognised yields zero; the
  // illegal flag is raised for unrecognised opcodes or a compressed-style
  // low bit pair.
  always_comb begin
    w_imm     = 32'd0;
    w_illegal = 1'b0;
    if (i_in_instr[1:0] != 2'b11)
      w_illegal = 1'b1;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        w_imm = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
      OP_STORE:
        w_imm = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
      OP_BRANCH:
        w_imm = {{19{i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                 i_in_instr[30:25], i_in_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {i_in_instr[31:12], 12'd0};
      OP_JAL:
        w_imm = {{11{i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                 i_in_instr[20], i_in_instr[30:21], 1'b0};
      OP_REG, OP_FENCE:
        w_imm = 32'd0;
      default:
        w_illegal = 1'b1;
    endcase
  end

  // Occupancy state register; reset empties the stage unconditionally.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= EMPTY;
    else
      r_state <= w_nextState;
  end

  // Next occupancy: flush beats everything, a new accept refills, and a
  // downstream take without a refill drains the stage.
  always_comb begin
    w_nextState = r_state;
    if (i_flush)
      w_nextState = EMPTY;
    else if (w_accept)
      w_nextState = FULL;
    else if ((r_state == FULL) && i_out_ready)
      w_nextState = EMPTY;
  end

  // Decoded payload: loads only on accept, otherwise holds so the
  // downstream stage sees stable fields while stalled or after draining.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out_pc        <= 32'd0;
      o_out_rs1_value <= 32'd0;
      o_out_rs2_value <= 32'd0;
      o_out_imm       <= 32'd0;
      o_out_rd        <= 5'd0;
      o_out_opcode    <= 7'd0;
      o_out_funct3    <= 3'd0;
      o_out_funct7    <= 7'd0;
      o_out_illegal   <= 1'b0;
    end else if (w_accept) begin
      o_out_pc        <= i_in_pc;
      o_out_rs1_value <= w_rs1Value;
      o_out_rs2_value <= w_rs2Value;
      o_out_imm       <= w_imm;
      o_out_rd        <= i_in_instr[11:7];
      o_out_opcode    <= w_opcode;
      o_out_funct3    <= i_in_instr[14:12];
      o_out_funct7    <= i_in_instr[31:25];
      o_out_illegal   <= w_illegal;
    end
  end

endmodule
